// File: rtl/seg_disp_pkg.sv
// Shared constants for the 7-segment scan controller: state encoding, all-off patterns,
// default digit count.
package seg_disp_pkg;

    localparam int unsigned NDIG_DEFAULT = 8;

    localparam logic ST_BLANK = 1'b0;
    localparam logic ST_SHOW  = 1'b1;

    localparam logic [7:0] AN_ALL_OFF  = 8'hFF;
    localparam logic [7:0] SEG_ALL_OFF = 8'hFF;

endpackage

// File: rtl/scan_slot_timer.sv
// Slot timer: counts cycles within a digit slot, flags the guard window and slot/frame ends,
// and steps the digit index.
module scan_slot_timer
    import seg_disp_pkg::*;
#(
    parameter int unsigned NDIG  = NDIG_DEFAULT,
    parameter int unsigned DIV   = 100000,
    parameter int unsigned GUARD = 2000,
    localparam int unsigned IW   = (NDIG > 1) ? $clog2(NDIG) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          slot_end,
    output logic          in_guard,
    output logic          guard_last,
    output logic [IW-1:0] idx,
    output logic          frame_end
);

    localparam int unsigned CW = $clog2(DIV);

    localparam logic [CW-1:0] CntLast   = CW'(DIV - 1);
    localparam logic [CW-1:0] GuardLen  = CW'(GUARD);
    localparam logic [CW-1:0] GuardLast = CW'(GUARD - 1);
    localparam logic [IW-1:0] IdxLast   = IW'(NDIG - 1);

    logic [CW-1:0] cnt_q;
    logic [IW-1:0] idx_q;

    assign slot_end   = (cnt_q == CntLast);
    assign in_guard   = (cnt_q < GuardLen);
    assign guard_last = (cnt_q == GuardLast);
    assign frame_end  = slot_end && (idx_q == IdxLast);
    assign idx        = idx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= slot_end ? '0 : cnt_q + CW'(1);
            if (slot_end) begin
                idx_q <= (idx_q == IdxLast) ? '0 : idx_q + IW'(1);
            end
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// 8-digit common-anode scan controller with blank guard, frame-synchronous data update and
// digit mask. Define SEG_LEAD_ZERO_BLANK_EN to also blank leading zero digits.
module seg_scan_ctrl
    import seg_disp_pkg::*;
#(
    parameter int unsigned NDIG  = NDIG_DEFAULT,
    parameter int unsigned DIV   = 100000,
    parameter int unsigned GUARD = 2000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4*NDIG-1:0] data_in,
    input  logic              load,
    input  logic [NDIG-1:0]   dig_mask,
    output logic [NDIG-1:0]   an,
    output logic [3:0]        code,
    output logic              blank,
    output logic              frame_done
);

    localparam int unsigned IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [NDIG-1:0] AnOff = AN_ALL_OFF[NDIG-1:0];

    logic          slot_end, in_guard, guard_last, frame_end;
    logic [IW-1:0] idx;

    scan_slot_timer #(
        .NDIG  (NDIG),
        .DIV   (DIV),
        .GUARD (GUARD)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .slot_end   (slot_end),
        .in_guard   (in_guard),
        .guard_last (guard_last),
        .idx        (idx),
        .frame_end  (frame_end)
    );

    // Display data: the active register only changes on a frame boundary.
    logic [4*NDIG-1:0] active_q, pending_q;
    logic              pend_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q     <= '0;
            pending_q    <= '0;
            pend_valid_q <= 1'b0;
        end else if (frame_end && load) begin
            active_q     <= data_in;
            pend_valid_q <= 1'b0;
        end else if (load) begin
            pending_q    <= data_in;
            pend_valid_q <= 1'b1;
        end else if (frame_end && pend_valid_q) begin
            active_q     <= pending_q;
            pend_valid_q <= 1'b0;
        end
    end

    logic [NDIG-1:0] lit_mask;

`ifdef SEG_LEAD_ZERO_BLANK_EN
    // keep[i] = some nibble at or above digit i is nonzero; digit 0 always stays lit.
    logic [NDIG-1:0] keep;

    always_comb begin
        keep = '0;
        keep[NDIG-1] = |active_q[4*NDIG-1 -: 4];
        for (int i = NDIG - 2; i >= 0; i--) begin
            keep[i] = keep[i+1] | (|active_q[4*i +: 4]);
        end
        keep[0] = 1'b1;
    end

    assign lit_mask = dig_mask & keep;
`else
    assign lit_mask = dig_mask;
`endif

    // FSM: state register / next-state / output decode.
    logic state_q, state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BLANK;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BLANK: if (guard_last) state_d = ST_SHOW;
            ST_SHOW:  if (slot_end)   state_d = ST_BLANK;
            default:  state_d = ST_BLANK;
        endcase
    end

    logic [NDIG-1:0] an_d, an_q;
    logic [3:0]      code_d, code_q;
    logic            blank_d, blank_q, frame_done_q;

    always_comb begin
        an_d    = AnOff;
        blank_d = 1'b1;
        code_d  = code_q;
        if (state_q == ST_SHOW && !in_guard) begin
            code_d = active_q[{idx, 2'b00} +: 4];
            if (lit_mask[idx]) begin
                an_d    = ~(NDIG'(1) << idx);
                blank_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_q         <= AnOff;
            code_q       <= '0;
            blank_q      <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            an_q         <= an_d;
            code_q       <= code_d;
            blank_q      <= blank_d;
            frame_done_q <= frame_end;
        end
    end

    assign an         = an_q;
    assign code       = code_q;
    assign blank      = blank_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: a cycle model pushes expected outputs, a monitor
// pops and compares on the falling edge; also checks guard gaps and one-hot anodes.
module tb_seg_scan_ctrl;
    import seg_disp_pkg::*;

    localparam int unsigned NDIG  = 4;
    localparam int unsigned DIV   = 8;
    localparam int unsigned GUARD = 2;
    localparam int unsigned FRAME = NDIG * DIV;
`ifdef SEG_LEAD_ZERO_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] data_in = 16'h0;
    logic        load = 1'b0;
    logic [3:0]  dig_mask = 4'hF;
    logic [3:0]  an, code;
    logic        blank, frame_done;

    seg_scan_ctrl #(
        .NDIG  (NDIG),
        .DIV   (DIV),
        .GUARD (GUARD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .load       (load),
        .dig_mask   (dig_mask),
        .an         (an),
        .code       (code),
        .blank      (blank),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic       blank;
        logic [3:0] code;
        logic       fd;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    int unsigned pos = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, req, $time);
        end
    endtask

    // Reference: cycle p after reset release is slot p/DIV, offset p%DIV; outputs appear one
    // edge later. Frame data = last load seen during the previous frame.
    initial begin : model
        logic [15:0] m_active, m_next;
        bit          m_next_v, lit, fend;
        logic [3:0]  m_code;
        int unsigned p, c, dig;
        exp_t        e;
        m_active = '0; m_next = '0; m_next_v = 0; m_code = '0; p = 0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_active = '0; m_next_v = 0; m_code = '0; p = 0;
                e = '{an: 4'hF, blank: 1'b1, code: 4'h0, fd: 1'b0};
            end else begin
                c    = p % DIV;
                dig  = (p / DIV) % NDIG;
                fend = ((p % FRAME) == FRAME - 1);
                lit  = (c >= GUARD) && dig_mask[dig] &&
                       (!LZ || dig == 0 || (m_active >> (4 * dig)) != 16'h0);
                if (c >= GUARD) m_code = m_active[4*dig +: 4];
                e.an    = lit ? ~(4'b0001 << dig) : 4'hF;
                e.blank = !lit;
                e.code  = m_code;
                e.fd    = fend;
                if (load) begin
                    m_next = data_in; m_next_v = 1;
                end
                if (fend) begin
                    if (m_next_v) m_active = m_next;
                    m_next_v = 0;
                end
                p++;
            end
            sb.push_back(e);
        end
    end

    initial begin : monitor
        exp_t e;
        int   gap, last, d;
        gap = 0; last = -1; d = 0;
        forever begin
            @(negedge clk);
            if (sb.size() == 0) begin
                checks++; failures++;
                $display("FAIL sb_empty: actual=empty required=entry at t=%0t", $time);
            end else begin
                e = sb.pop_front();
                check("an", 32'(an), 32'(e.an));
                check("blank", 32'(blank), 32'(e.blank));
                check("code", 32'(code), 32'(e.code));
                check("frame_done", 32'(frame_done), 32'(e.fd));
            end
            if (!rst_n) begin
                last = -1; gap = 0;
            end else if (an == 4'hF) begin
                gap++;
            end else begin
                check("an_onehot", 32'($countones(~an)), 32'd1);
                for (int i = 0; i < int'(NDIG); i++) if (!an[i]) d = i;
                if (last >= 0 && d != last) begin
                    checks++;
                    if (gap < int'(GUARD)) begin
                        failures++;
                        $display("FAIL guard_gap: actual=%0d required>=%0d at t=%0t",
                                 gap, GUARD, $time);
                    end
                end
                last = d; gap = 0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    task automatic step(input logic ld, input logic [15:0] d, input logic [3:0] m);
        @(negedge clk);
        load = ld; data_in = d; dig_mask = m; pos++;
    endtask

    initial begin : stim
        logic [15:0] r;
        logic [3:0]  m_cur;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1; pos = 0;

        // Load lands in frame 1; mid-frame load lands in frame 3.
        step(1'b1, 16'h4321, 4'hF);
        while (pos < 2 * FRAME + 10) step(1'b0, 16'h0, 4'hF);
        step(1'b1, 16'hBEEF, 4'hF);
        while (pos < 4 * FRAME + 30) step(1'b0, 16'h0, 4'hF);
        // Load exactly on the frame-end cycle.
        step(1'b1, 16'hA5C7, 4'hF);
        while (pos < 6 * FRAME) step(1'b0, 16'h0, 4'hF);

        while (pos < 6 * FRAME + DIV + 4) step(1'b0, 16'h0, 4'b0101);
        repeat (2) step(1'b0, 16'h0, 4'hF);
        repeat (2) step(1'b0, 16'h0, 4'b1101);
        while (pos < 8 * FRAME) step(1'b0, 16'h0, 4'b0101);

        m_cur = 4'hF;
        repeat (1500) begin
            r = 16'($urandom);
            r = r >> (4 * $urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) m_cur = 4'($urandom);
            step($urandom_range(0, 7) == 0, r, m_cur);
        end

        step(1'b1, 16'h0050, 4'hF);
        repeat (2 * FRAME) step(1'b0, 16'h0, 4'hF);
        step(1'b1, 16'h0000, 4'hF);
        repeat (2 * FRAME) step(1'b0, 16'h0, 4'hF);
        step(1'b1, 16'h1234, 4'hF);
        repeat (2 * FRAME) step(1'b0, 16'h0, 4'hF);

        // Reset while digit 2 is showing.
        while ((pos % FRAME) != 20) step(1'b0, 16'h0, 4'hF);
        check("pre_reset_an", 32'(an), 32'h0000000B);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_an", 32'(an), 32'h0000000F);
        check("async_reset_blank", 32'(blank), 32'd1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1; pos = 0;
        repeat (2 * FRAME) step(1'b0, 16'h0, 4'hF);

        @(negedge clk);
        #3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
